event_logger: RTL and testbench

EVENT_LOGGER -- requirements
Module: event_logger

---
 rtl/logger_pkg.sv | 24 ++
 rtl/event_logger_if.sv | 47 ++++
 rtl/event_logger_fifo.sv | 87 ++++++++
 rtl/event_logger.sv | 110 +++++++++++
 tb/tb_event_logger.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logger_pkg.sv
// logger_pkg: definitions shared by the event logger and its FIFO.
//   entry_type_e : type flag stored in the MSB of every log entry
//                  (normal event entry or drop-count marker).
//   TIME_LSB / event_lsb() / type_bit() : bit offsets of the fields
//                  inside an LDW = 1+SEW+ATW bit entry laid out as
//                  {type, event[SEW-1:0], time_or_count[ATW-1:0]}.
package logger_pkg;

   typedef enum logic {
      ENTRY_NORMAL = 1'b0,
      ENTRY_MARKER = 1'b1
   } entry_type_e;

   localparam int TIME_LSB = 0;

   function automatic int event_lsb(input int atw);
      return atw;
   endfunction

   function automatic int type_bit(input int sew, input int atw);
      return atw + sew;
   endfunction

endpackage

// File: rtl/event_logger_if.sv
// event_logger_if: the three streams of the event logger.
//   sti_* : sample input stream   (tvalid/tevent/tdata in, tready out)
//   sto_* : sample output stream  (tvalid/tevent/tdata out, tready in)
//   stl_* : log stream            (tvalid/tdata out, tready in)
// Modports:
//   slave  : the logger side
//   master : the environment side (source of sti, sink of sto and stl)
interface event_logger_if #(
   parameter int SEW = 2,
   parameter int SDW = 32,
   parameter int ATW = 48,
   parameter int LDW = 1 + SEW + ATW
);

   logic           sti_tready;
   logic           sti_tvalid;
   logic [SEW-1:0] sti_tevent;
   logic [SDW-1:0] sti_tdata;

   logic           sto_tready;
   logic           sto_tvalid;
   logic [SEW-1:0] sto_tevent;
   logic [SDW-1:0] sto_tdata;

   logic           stl_tready;
   logic           stl_tvalid;
   logic [LDW-1:0] stl_tdata;

   modport slave (
      output sti_tready,
      input  sti_tvalid, sti_tevent, sti_tdata,
      input  sto_tready,
      output sto_tvalid, sto_tevent, sto_tdata,
      input  stl_tready,
      output stl_tvalid, stl_tdata
   );

   modport master (
      input  sti_tready,
      output sti_tvalid, sti_tevent, sti_tdata,
      output sto_tready,
      input  sto_tvalid, sto_tevent, sto_tdata,
      output stl_tready,
      input  stl_tvalid, stl_tdata
   );

endinterface

// File: rtl/event_logger_fifo.sv
// event_logger_fifo: log storage with a registered output stage.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write wr_data this cycle (ignored while full)
//   full      : occupancy equals LEN (state at start of cycle)
//   level     : occupancy, counting the entry held in the output register
//   rd_ready  : downstream accepts rd_data
//   rd_valid  : rd_data holds an entry
//   rd_data   : registered output entry
module event_logger_fifo #(
   parameter int LDW = 51,
   parameter int LEN = 32,
   localparam int AW = $clog2(LEN),
   localparam int PW = AW + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_en,
   input  logic [LDW-1:0] wr_data,
   output logic           full,
   output logic [PW-1:0]  level,
   input  logic           rd_ready,
   output logic           rd_valid,
   output logic [LDW-1:0] rd_data
);

   logic [LDW-1:0] mem [LEN];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr_seen;
   logic           mem_empty;
   logic           pop_out;
   logic           rd_en;
   logic           mem_rd;
   logic           wr_do;

   // The output register counts toward occupancy, so an entry frees its
   // slot only when the consumer takes it; full then blocks writes even
   // if a handshake happens in the same cycle.
   assign full    = (level == PW'(LEN));
   assign wr_do   = wr_en & ~full;

   // The read side sees the write pointer one cycle late: a freshly
   // written word becomes readable on the following cycle.
   assign mem_empty = (wr_ptr_seen == rd_ptr);
   assign pop_out   = rd_valid & rd_ready;
   assign rd_en     = (~mem_empty & ~rd_valid) | pop_out;
   assign mem_rd    = rd_en & ~mem_empty;

   // Storage and output data are not reset; pointers and valid qualify them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_do) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
         end
         if (mem_rd) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wr_ptr_seen <= '0;
         level       <= '0;
         rd_valid    <= 1'b0;
      end else begin
         if (wr_do) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         wr_ptr_seen <= wr_ptr;
         if (mem_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_valid <= ~mem_empty;
         end
         case ({wr_do, pop_out})
            2'b10:   level <= level + PW'(1);
            2'b01:   level <= level - PW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/event_logger.sv
// event_logger: passes a sample stream straight through and logs selected
// events, with a timestamp, into a FIFO read out on the stl stream.
//   clk, rst   : clock, synchronous active-high reset
//   cfg_ena    : logging enable
//   cfg_tmode  : timestamp mode (0 = count sti transfers, 1 = count cycles)
//   cfg_emask  : per-bit event enable mask
//   err_full   : one-cycle pulse per event dropped while the log was full
//   sts_level  : log occupancy
//   bus        : sti/sto/stl streams (event_logger_if.slave)
// Log entries are {type, event, time} for normal entries and
// {type, zeros, dropped-count} for markers.
module event_logger
   import logger_pkg::*;
#(
   parameter int SEW = 2,
   parameter int SDW = 32,
   parameter int ATW = 48,
   parameter int LEN = 32,
   localparam int LDW = 1 + SEW + ATW,
   localparam int LVW = $clog2(LEN) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cfg_ena,
   input  logic           cfg_tmode,
   input  logic [SEW-1:0] cfg_emask,
   output logic           err_full,
   output logic [LVW-1:0] sts_level,
   event_logger_if.slave  bus
);

   localparam int EVENT_POS = event_lsb(ATW);
   localparam int TYPE_POS  = type_bit(SEW, ATW);

   logic [SEW-1:0] masked_event;
   logic           transfer;
   logic           candidate;
   logic [ATW-1:0] atc;
   logic [ATW-1:0] lost;
   logic [ATW-1:0] marker_count;
   logic           full;
   logic           wr_en;
   logic [LDW-1:0] wr_entry;

   assign bus.sti_tready = bus.sto_tready;
   assign bus.sto_tvalid = bus.sti_tvalid;
   assign bus.sto_tevent = bus.sti_tevent;
   assign bus.sto_tdata  = bus.sti_tdata;

   assign masked_event = bus.sti_tevent & cfg_emask;
   assign transfer     = bus.sti_tvalid & bus.sto_tready;
   assign candidate    = transfer & cfg_ena & (|masked_event);

   // A candidate arriving in the marker cycle is counted in the marker
   // instead of getting its own entry.
   assign marker_count = (candidate && (lost != '1)) ? lost + ATW'(1) : lost;

   // A pending marker takes the write slot ahead of any new event.
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = '0;
      if (!full) begin
         if (lost != '0) begin
            wr_en                            = 1'b1;
            wr_entry[TYPE_POS]               = ENTRY_MARKER;
            wr_entry[EVENT_POS +: SEW]       = '0;
            wr_entry[TIME_LSB +: ATW]        = marker_count;
         end else if (candidate) begin
            wr_en                            = 1'b1;
            wr_entry[TYPE_POS]               = ENTRY_NORMAL;
            wr_entry[EVENT_POS +: SEW]       = masked_event;
            wr_entry[TIME_LSB +: ATW]        = atc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         atc      <= '0;
         lost     <= '0;
         err_full <= 1'b0;
      end else begin
         if (cfg_ena && (cfg_tmode || transfer)) begin
            atc <= atc + ATW'(1);
         end
         err_full <= full & candidate;
         if (!full && (lost != '0)) begin
            lost <= '0;
         end else if (full && candidate && (lost != '1)) begin
            lost <= lost + ATW'(1);
         end
      end
   end

   event_logger_fifo #(
      .LDW (LDW),
      .LEN (LEN)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_entry),
      .full     (full),
      .level    (sts_level),
      .rd_ready (bus.stl_tready),
      .rd_valid (bus.stl_tvalid),
      .rd_data  (bus.stl_tdata)
   );

endmodule

// File: tb/tb_event_logger.sv
// tb_event_logger: directed and randomized checks of event_logger.
// Two instances share all inputs: dut4 (LEN=4) for the directed scenarios
// and dut8 (LEN=8) for the randomized ordering/accounting run.
module tb_event_logger;

   localparam int SEW = 2;
   localparam int SDW = 32;
   localparam int ATW = 48;
   localparam int LDW = 1 + SEW + ATW;

   typedef logic [LDW-1:0] entry_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_ena = 1'b0;
   logic           cfg_tmode = 1'b0;
   logic [SEW-1:0] cfg_emask = '0;
   logic           sti_tvalid = 1'b0;
   logic [SEW-1:0] sti_tevent = '0;
   logic [SDW-1:0] sti_tdata = '0;
   logic           sto_tready = 1'b0;
   logic           stl_tready = 1'b0;

   logic           err_full4;
   logic [2:0]     level4;
   logic           err_full8;
   logic [3:0]     level8;

   int tests_run = 0;
   int tests_failed = 0;

   entry_t q4[$];
   entry_t q8[$];

   event_logger_if #(.SEW(SEW), .SDW(SDW), .ATW(ATW)) if4 ();
   event_logger_if #(.SEW(SEW), .SDW(SDW), .ATW(ATW)) if8 ();

   assign if4.sti_tvalid = sti_tvalid;
   assign if4.sti_tevent = sti_tevent;
   assign if4.sti_tdata  = sti_tdata;
   assign if4.sto_tready = sto_tready;
   assign if4.stl_tready = stl_tready;
   assign if8.sti_tvalid = sti_tvalid;
   assign if8.sti_tevent = sti_tevent;
   assign if8.sti_tdata  = sti_tdata;
   assign if8.sto_tready = sto_tready;
   assign if8.stl_tready = stl_tready;

   event_logger #(.SEW(SEW), .SDW(SDW), .ATW(ATW), .LEN(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .cfg_ena   (cfg_ena),
      .cfg_tmode (cfg_tmode),
      .cfg_emask (cfg_emask),
      .err_full  (err_full4),
      .sts_level (level4),
      .bus       (if4.slave)
   );

   event_logger #(.SEW(SEW), .SDW(SDW), .ATW(ATW), .LEN(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .cfg_ena   (cfg_ena),
      .cfg_tmode (cfg_tmode),
      .cfg_emask (cfg_emask),
      .err_full  (err_full8),
      .sts_level (level8),
      .bus       (if8.slave)
   );

   always #5 clk = ~clk;

   // Collect every accepted log entry (reset cycles are not transfers).
   always @(posedge clk) begin
      if (!rst && if4.stl_tvalid && if4.stl_tready) q4.push_back(if4.stl_tdata);
      if (!rst && if8.stl_tvalid && if8.stl_tready) q8.push_back(if8.stl_tdata);
   end

   function automatic entry_t mk(input logic typ, input logic [SEW-1:0] ev, input logic [ATW-1:0] t);
      return {typ, ev, t};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      sti_tvalid = 1'b0;
      sti_tevent = '0;
      sti_tdata  = '0;
      sto_tready = 1'b1;
      stl_tready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      q4.delete();
      q8.delete();
   endtask

   task automatic drain(input int n);
      stl_tready = 1'b1;
      repeat (n) @(negedge clk);
      stl_tready = 1'b0;
   endtask

   task automatic candidate(input logic [SEW-1:0] ev);
      sti_tvalid = 1'b1;
      sti_tevent = ev;
      sti_tdata  = $urandom;
      sto_tready = 1'b1;
      @(negedge clk);
      sti_tvalid = 1'b0;
   endtask

   task automatic test_reset();
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      tests_run++;
      if (if4.stl_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL reset_tvalid: got %b expected 0", if4.stl_tvalid);
      end
      tests_run++;
      if (level4 !== 3'd0) begin
         tests_failed++; $display("[TB] FAIL reset_level: got %0d expected 0", level4);
      end
      tests_run++;
      if (err_full4 !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL reset_err_full: got %b expected 0", err_full4);
      end
      tests_run++;
      if ({if8.stl_tvalid, level8, err_full8} !== 6'd0) begin
         tests_failed++; $display("[TB] FAIL reset_dut8: got %b expected 0", {if8.stl_tvalid, level8, err_full8});
      end
   endtask

   task automatic test_passthrough();
      logic [SDW+SEW+1:0] got, exp;
      cfg_ena = 1'b0; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         sti_tvalid = 1'($urandom_range(0, 1));
         sti_tevent = 2'($urandom_range(0, 3));
         sti_tdata  = $urandom;
         sto_tready = 1'($urandom_range(0, 1));
         #1;
         got = {if4.sto_tvalid, if4.sto_tevent, if4.sto_tdata, if4.sti_tready};
         exp = {sti_tvalid, sti_tevent, sti_tdata, sto_tready};
         tests_run++;
         if (got !== exp) begin
            tests_failed++; $display("[TB] FAIL passthrough: got %h expected %h", got, exp);
         end
         @(negedge clk);
      end
      sti_tvalid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (level4 !== 3'd0) begin
         tests_failed++; $display("[TB] FAIL disabled_level: got %0d expected 0", level4);
      end
   endtask

   task automatic test_basic();
      entry_t exp[$];
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      sti_tvalid = 1'b1; sto_tready = 1'b1; sti_tevent = 2'b01;
      @(negedge clk);
      tests_run++;
      if (if4.stl_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL basic_tvalid_n1: got %b expected 0", if4.stl_tvalid);
      end
      sti_tevent = 2'b00;
      @(negedge clk);
      tests_run++;
      if (if4.stl_tvalid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL basic_tvalid_n2a: got %b expected 0", if4.stl_tvalid);
      end
      sti_tevent = 2'b10;
      @(negedge clk);
      sti_tvalid = 1'b0;
      tests_run++;
      if (if4.stl_tvalid !== 1'b1 || if4.stl_tdata !== mk(1'b0, 2'b01, 48'd0)) begin
         tests_failed++; $display("[TB] FAIL basic_first_out: got %b/%h expected 1/%h",
                                  if4.stl_tvalid, if4.stl_tdata, mk(1'b0, 2'b01, 48'd0));
      end
      tests_run++;
      if (level4 !== 3'd2) begin
         tests_failed++; $display("[TB] FAIL basic_level: got %0d expected 2", level4);
      end
      drain(8);
      exp = '{mk(1'b0, 2'b01, 48'd0), mk(1'b0, 2'b10, 48'd2)};
      tests_run++;
      if (q4.size() != exp.size()) begin
         tests_failed++; $display("[TB] FAIL basic_count: got %0d expected %0d", q4.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            tests_run++;
            if (q4[i] !== exp[i]) begin
               tests_failed++; $display("[TB] FAIL basic_entry%0d: got %h expected %h", i, q4[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_tmode();
      entry_t exp[$];
      cfg_ena = 1'b1; cfg_tmode = 1'b1; cfg_emask = 2'b10;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      candidate(2'b01);
      @(negedge clk);
      @(negedge clk);
      candidate(2'b10);
      drain(8);
      exp = '{mk(1'b0, 2'b10, 48'd5)};
      tests_run++;
      if (q4.size() != exp.size()) begin
         tests_failed++; $display("[TB] FAIL tmode_count: got %0d expected %0d", q4.size(), exp.size());
      end else begin
         tests_run++;
         if (q4[0] !== exp[0]) begin
            tests_failed++; $display("[TB] FAIL tmode_entry: got %h expected %h", q4[0], exp[0]);
         end
      end
   endtask

   task automatic test_full();
      entry_t exp[$];
      int pulses;
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         sti_tvalid = 1'b1; sti_tevent = 2'b01; sto_tready = 1'b1;
         @(negedge clk);
         if (err_full4 === 1'b1) pulses++;
      end
      sti_tvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (err_full4 === 1'b1) pulses++;
      end
      tests_run++;
      if (pulses != 2) begin
         tests_failed++; $display("[TB] FAIL full_err_pulses: got %0d expected 2", pulses);
      end
      tests_run++;
      if (level4 !== 3'd4 || if4.stl_tvalid !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL full_level: got %0d/%b expected 4/1", level4, if4.stl_tvalid);
      end
      stl_tready = 1'b1;
      @(negedge clk);
      stl_tready = 1'b0;
      tests_run++;
      if (level4 !== 3'd3) begin
         tests_failed++; $display("[TB] FAIL full_after_read: got %0d expected 3", level4);
      end
      @(negedge clk);
      tests_run++;
      if (level4 !== 3'd4) begin
         tests_failed++; $display("[TB] FAIL full_marker_level: got %0d expected 4", level4);
      end
      drain(10);
      exp = '{mk(1'b0, 2'b01, 48'd0), mk(1'b0, 2'b01, 48'd1), mk(1'b0, 2'b01, 48'd2),
              mk(1'b0, 2'b01, 48'd3), mk(1'b1, 2'b00, 48'd2)};
      tests_run++;
      if (q4.size() != exp.size()) begin
         tests_failed++; $display("[TB] FAIL full_count: got %0d expected %0d", q4.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            tests_run++;
            if (q4[i] !== exp[i]) begin
               tests_failed++; $display("[TB] FAIL full_entry%0d: got %h expected %h", i, q4[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_marker_fold();
      entry_t exp[$];
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      for (int i = 0; i < 5; i++) candidate(2'b01);
      @(negedge clk);
      stl_tready = 1'b1;
      @(negedge clk);
      stl_tready = 1'b0;
      candidate(2'b10);
      tests_run++;
      if (level4 !== 3'd4 || err_full4 !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL fold_level: got %0d/%b expected 4/0", level4, err_full4);
      end
      @(negedge clk);
      drain(10);
      exp = '{mk(1'b0, 2'b01, 48'd0), mk(1'b0, 2'b01, 48'd1), mk(1'b0, 2'b01, 48'd2),
              mk(1'b0, 2'b01, 48'd3), mk(1'b1, 2'b00, 48'd2)};
      tests_run++;
      if (q4.size() != exp.size()) begin
         tests_failed++; $display("[TB] FAIL fold_count: got %0d expected %0d", q4.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            tests_run++;
            if (q4[i] !== exp[i]) begin
               tests_failed++; $display("[TB] FAIL fold_entry%0d: got %h expected %h", i, q4[i], exp[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      int waited;
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      for (int i = 0; i < 3; i++) candidate(2'b11);
      waited = 0;
      while (if4.stl_tvalid !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      tests_run++;
      if (if4.stl_tvalid !== 1'b1 || level4 !== 3'd3) begin
         tests_failed++; $display("[TB] FAIL mid_prefill: got %b/%0d expected 1/3", if4.stl_tvalid, level4);
      end
      rst = 1'b1; stl_tready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (if4.stl_tvalid !== 1'b0 || level4 !== 3'd0) begin
         tests_failed++; $display("[TB] FAIL mid_after_rst: got %b/%0d expected 0/0", if4.stl_tvalid, level4);
      end
      repeat (10) @(negedge clk);
      stl_tready = 1'b0;
      tests_run++;
      if (q4.size() != 0) begin
         tests_failed++; $display("[TB] FAIL mid_discard: got %0d entries expected 0", q4.size());
      end
      do_reset();
      for (int i = 0; i < 5; i++) candidate(2'b01);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drain(10);
      candidate(2'b10);
      drain(8);
      tests_run++;
      if (q4.size() != 1) begin
         tests_failed++; $display("[TB] FAIL mid_marker_dropped: got %0d entries expected 1", q4.size());
      end else begin
         tests_run++;
         if (q4[0] !== mk(1'b0, 2'b10, 48'd0)) begin
            tests_failed++; $display("[TB] FAIL mid_first_entry: got %h expected %h", q4[0], mk(1'b0, 2'b10, 48'd0));
         end
      end
   endtask

   task automatic test_random_order();
      logic [SEW-1:0] evs[100];
      int issued, cyc, next;
      entry_t e;
      cfg_ena = 1'b1; cfg_tmode = 1'b0; cfg_emask = 2'b11;
      do_reset();
      issued = 0;
      cyc = 0;
      while (issued < 100 && cyc < 4000) begin
         stl_tready = ($urandom_range(0, 3) == 0);
         sto_tready = ($urandom_range(0, 3) != 0);
         sti_tvalid = 1'($urandom_range(0, 1));
         sti_tevent = 2'($urandom_range(1, 3));
         sti_tdata  = $urandom;
         if (sti_tvalid && sto_tready) begin
            evs[issued] = sti_tevent;
            issued++;
         end
         @(negedge clk);
         cyc++;
      end
      sti_tvalid = 1'b0;
      tests_run++;
      if (issued != 100) begin
         tests_failed++; $display("[TB] FAIL random_issue_timeout: got %0d expected 100", issued);
      end
      drain(60);
      next = 0;
      foreach (q8[i]) begin
         e = q8[i];
         tests_run++;
         if (e[LDW-1] == 1'b0) begin
            if (next >= 100) begin
               tests_failed++; $display("[TB] FAIL random_extra_entry: got %h expected none", e);
            end else if (e[ATW-1:0] !== 48'(next) || e[ATW+SEW-1:ATW] !== evs[next]) begin
               tests_failed++; $display("[TB] FAIL random_normal: got %h expected %h", e, mk(1'b0, evs[next], 48'(next)));
            end
            next++;
         end else begin
            if (e[ATW+SEW-1:ATW] !== 2'b00 || e[ATW-1:0] == 48'd0 || e[ATW-1:0] > 48'd100) begin
               tests_failed++; $display("[TB] FAIL random_marker: got %h expected count 1..100 with zero event", e);
               next = 1000;
            end else begin
               next += int'(e[ATW-1:0]);
            end
         end
      end
      tests_run++;
      if (next != 100) begin
         tests_failed++; $display("[TB] FAIL random_total: got %0d expected 100", next);
      end
      tests_run++;
      if (level8 !== 4'd0) begin
         tests_failed++; $display("[TB] FAIL random_level: got %0d expected 0", level8);
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_basic();
      test_tmode();
      test_full();
      test_marker_fold();
      test_reset_midstream();
      test_random_order();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
